// File: rtl/mem_block_arbiter.sv
// ---------------------------------------------------------------------------
// mem_block_arbiter
//
// Shares one block-wide memory port between three requesters: I-cache fills,
// D-cache fills and D-cache writebacks. A single transaction is outstanding at
// a time, and the arbiter returns to IDLE for at least one cycle between
// transactions.
//
// Arbitration, sampled in IDLE and granted on the next rising edge:
//   - a D-cache writeback always wins, so a dirty victim leaves before its
//     refill can overwrite it;
//   - between the two read classes a 1-bit round-robin picks the class not
//     served last. After reset the I-cache counts as served last.
//
// In a grant state the memory request and the block-aligned address are
// held. The matching memory valid ends the transaction. The requester's valid
// pulses only if it is still requesting at that moment. Returned read data is
// always captured. If no valid arrives, the watchdog counter reaches TIMEOUT
// on the TIMEOUT-th edge after the grant. The transaction is then abandoned
// with a one-cycle timeout_err pulse, and a valid on that same edge still wins.
//
// Ports
//   CLK, RESET        clock, asynchronous active-low reset
//   i_req/i_addr      I-cache fill request   -> i_rdata, i_valid
//   d_rd_req/addr     D-cache fill request   -> d_rd_data, d_rd_valid
//   d_wr_req/addr/data D-cache writeback     -> d_wr_valid
//   m_*               shared memory block port
//   busy              a transaction is granted
//   timeout_err       one-cycle pulse when a grant is abandoned
// ---------------------------------------------------------------------------
module mem_block_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BLK_W-1:0]  i_rdata,
  output logic              i_valid,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic [BLK_W-1:0]  d_rd_data,
  output logic              d_rd_valid,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [BLK_W-1:0]  d_wr_data,
  output logic              d_wr_valid,
  output logic              m_rd_req,
  output logic              m_wr_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [BLK_W-1:0]  m_wdata,
  input  logic [BLK_W-1:0]  m_rdata,
  input  logic              m_rd_valid,
  input  logic              m_wr_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_DRD, GNT_DWR} stateT;

  stateT            state;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             lastWasI;   // 1: the I-cache was the read class served last

  // Blocks are 32 bytes, so the low five address bits are dropped.
  function automatic logic [ADDR_W-1:0] blockAlign(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(31);
  endfunction

  assign waitCntNext = waitCnt + CNT_W'(1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      waitCnt     <= '0;
      lastWasI    <= 1'b1;
      m_rd_req    <= 1'b0;
      m_wr_req    <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rd_data   <= '0;
      i_valid     <= 1'b0;
      d_rd_valid  <= 1'b0;
      d_wr_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // The completion and timeout flags are pulses by default.
      i_valid     <= 1'b0;
      d_rd_valid  <= 1'b0;
      d_wr_valid  <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (d_wr_req) begin
            state    <= GNT_DWR;
            m_wr_req <= 1'b1;
            m_addr   <= blockAlign(d_wr_addr);
            m_wdata  <= d_wr_data;
            busy     <= 1'b1;
          end else if (d_rd_req && (!i_req || lastWasI)) begin
            state    <= GNT_DRD;
            m_rd_req <= 1'b1;
            m_addr   <= blockAlign(d_rd_addr);
            lastWasI <= 1'b0;
            busy     <= 1'b1;
          end else if (i_req) begin
            state    <= GNT_I;
            m_rd_req <= 1'b1;
            m_addr   <= blockAlign(i_addr);
            lastWasI <= 1'b1;
            busy     <= 1'b1;
          end
        end

        GNT_I, GNT_DRD: begin
          waitCnt <= waitCntNext;
          if (m_rd_valid) begin
            state    <= IDLE;
            m_rd_req <= 1'b0;
            busy     <= 1'b0;
            // A requester that withdrew still gets its data but no pulse.
            if (state == GNT_I) begin
              i_rdata <= m_rdata;
              i_valid <= i_req;
            end else begin
              d_rd_data  <= m_rdata;
              d_rd_valid <= d_rd_req;
            end
          end else if (waitCntNext == CNT_W'(TIMEOUT)) begin
            state       <= IDLE;
            m_rd_req    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end

        GNT_DWR: begin
          waitCnt <= waitCntNext;
          if (m_wr_valid) begin
            state      <= IDLE;
            m_wr_req   <= 1'b0;
            busy       <= 1'b0;
            d_wr_valid <= d_wr_req;
          end else if (waitCntNext == CNT_W'(TIMEOUT)) begin
            state       <= IDLE;
            m_wr_req    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          m_rd_req <= 1'b0;
          m_wr_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
